// File: rtl/traffic_lights_monitor_if.sv
// Lamp lines between the traffic-light controller (master) and any observer
// (slave), such as traffic_lights_monitor.
interface traffic_lights_monitor_if;
  logic red;
  logic yellow;
  logic green;

  modport master (output red, output yellow, output green);
  modport slave  (input  red, input  yellow, input  green);
endinterface : traffic_lights_monitor_if

// File: rtl/traffic_lights_monitor.sv
// Passive checker for traffic-light lamp patterns, phase order and phase lengths.
// Define TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN to build the phase-length checker.
module traffic_lights_monitor #(
  parameter int RED_TIME        = 1,
  parameter int RED_YELLOW_TIME = 2,
  parameter int GREEN_TIME      = 3,
  parameter int YELLOW_TIME     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_lights_monitor_if.slave  lamps,
  output logic [1:0]               phase,
  output logic                     locked,
  output logic                     err_pattern,
  output logic                     err_sequence,
  output logic                     err_duration,
  output logic [7:0]               err_count,
  output logic [15:0]              cycle_count
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [1:0] PH_RED    = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  // Phase lengths are held in an 8-bit saturating counter, so 255 is reserved.
  if (RED_TIME < 1 || RED_TIME > 254 || RED_YELLOW_TIME < 1 || RED_YELLOW_TIME > 254 ||
      GREEN_TIME < 1 || GREEN_TIME > 254 || YELLOW_TIME < 1 || YELLOW_TIME > 254) begin : g_bad_time
    $error("traffic_lights_monitor: *_TIME parameters must lie in 1..254");
  end

  state_t     state, state_n;
  logic [2:0] pat, prev_pat;
  logic       pat_legal;
  logic [1:0] pat_phase;
  logic [1:0] phase_n;
  logic       pattern_n, sequence_n, duration_n, wrap_n;

  assign pat = {lamps.red, lamps.yellow, lamps.green};

  always_comb begin
    pat_legal = 1'b1;
    pat_phase = PH_RED;
    unique case (pat)
      3'b100:  pat_phase = 2'd0;
      3'b110:  pat_phase = 2'd1;
      3'b001:  pat_phase = 2'd2;
      3'b010:  pat_phase = 2'd3;
      default: pat_legal = 1'b0;
    endcase
  end

`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
  logic [7:0] run_cnt, run_n, expected;

  always_comb begin
    unique case (phase)
      2'd0:    expected = 8'(RED_TIME);
      2'd1:    expected = 8'(RED_YELLOW_TIME);
      2'd2:    expected = 8'(GREEN_TIME);
      default: expected = 8'(YELLOW_TIME);
    endcase
  end
`endif

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    pattern_n  = 1'b0;
    sequence_n = 1'b0;
    duration_n = 1'b0;
    wrap_n     = 1'b0;
`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
    run_n      = run_cnt;
`endif
    unique case (state)
      HUNT: begin
        if (!pat_legal) begin
          pattern_n = 1'b1;
        end else if (pat != prev_pat) begin
          // Entry length is counted from here but not checked against anything.
          state_n = TRACK;
          phase_n = pat_phase;
`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
          run_n   = 8'd1;
`endif
        end
      end
      TRACK: begin
        if (!pat_legal) begin
          pattern_n = 1'b1;
          state_n   = HUNT;
        end else if (pat_phase == phase) begin
`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
          run_n      = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
          duration_n = (run_cnt == expected);
`endif
        end else begin
          // Resync to whatever phase was observed, even after a sequence error.
          sequence_n = (pat_phase != phase + 2'd1);
          wrap_n     = (phase == PH_YELLOW) && (pat_phase == PH_RED);
          phase_n    = pat_phase;
`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
          duration_n = (run_cnt < expected);
          run_n      = 8'd1;
`endif
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      prev_pat     <= 3'b000;
      phase        <= PH_RED;
      locked       <= 1'b0;
      err_pattern  <= 1'b0;
      err_sequence <= 1'b0;
      err_duration <= 1'b0;
      err_count    <= 8'd0;
      cycle_count  <= 16'd0;
    end else begin
      state        <= state_n;
      prev_pat     <= pat;
      phase        <= phase_n;
      locked       <= (state_n == TRACK);
      err_pattern  <= pattern_n;
      err_sequence <= sequence_n;
      err_duration <= duration_n;
      if ((pattern_n || sequence_n || duration_n) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (wrap_n)
        cycle_count <= cycle_count + 16'd1;
    end
  end

`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_cnt <= 8'd0;
    else       run_cnt <= run_n;
  end
`endif

endmodule : traffic_lights_monitor

// File: tb/tb_traffic_lights_monitor.sv
// Directed bench for traffic_lights_monitor: stimulus pushes hand-computed
// expectations into a scoreboard queue, a monitor pops one per sampled edge.
module tb_traffic_lights_monitor;

`ifdef TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] RY  = 3'b110;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] BAD = 3'b111;

  typedef struct {
    logic        locked;
    logic [1:0]  phase;
    logic        ep, es, ed;
    logic [7:0]  ec;
    logic [15:0] cc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  phase;
  logic        locked, err_pattern, err_sequence, err_duration;
  logic [7:0]  err_count;
  logic [15:0] cycle_count;

  traffic_lights_monitor_if lamps ();

  traffic_lights_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .lamps        (lamps),
    .phase        (phase),
    .locked       (locked),
    .err_pattern  (err_pattern),
    .err_sequence (err_sequence),
    .err_duration (err_duration),
    .err_count    (err_count),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  exp_t sb[$];
  int   exp_err = 0;
  int   exp_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (sample %0d): got %0h expected %0h", name, popped, act, exp);
    end
  endtask

  // Called on a negedge: drive the lamps, queue the expected response, move on.
  task automatic step(input logic [2:0] p, input logic lk, input logic [1:0] ph,
                      input bit ep, input bit es, input bit ed, input bit cyc);
    exp_t e;
    bit   edx;
    edx = ed & DUR;
    {lamps.red, lamps.yellow, lamps.green} = p;
    if (ep || es || edx) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    if (cyc) exp_cyc++;
    e.locked = lk; e.phase = ph;
    e.ep = ep; e.es = es; e.ed = edx;
    e.ec = 8'(exp_err); e.cc = 16'(exp_cyc);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_phase"},  32'(phase),        0);
    check({tag, "_locked"}, 32'(locked),       0);
    check({tag, "_errs"},   32'({err_pattern, err_sequence, err_duration}), 0);
    check({tag, "_ecnt"},   32'(err_count),    0);
    check({tag, "_ccnt"},   32'(cycle_count),  0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("locked", 32'(locked), 32'(e.locked));
        if (e.locked) check("phase", 32'(phase), 32'(e.phase));
        check("err_pattern",  32'(err_pattern),  32'(e.ep));
        check("err_sequence", 32'(err_sequence), 32'(e.es));
        check("err_duration", 32'(err_duration), 32'(e.ed));
        check("err_count",    32'(err_count),    32'(e.ec));
        check("cycle_count",  32'(cycle_count),  32'(e.cc));
        popped++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1;
    {lamps.red, lamps.yellow, lamps.green} = R;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Controller-like legal run with default timing, 10-cycle period.
    for (int i = 0; i < 100; i++) begin
      int p;
      p = i % 10;
      if (p == 0)     step(R,  1'b1, 2'd0, 0, 0, 0, i != 0);
      else if (p < 3) step(RY, 1'b1, 2'd1, 0, 0, 0, 0);
      else if (p < 6) step(G,  1'b1, 2'd2, 0, 0, 0, 0);
      else            step(Y,  1'b1, 2'd3, 0, 0, 0, 0);
    end

    // Illegal 111 mid-GREEN, then relock directly on YELLOW.
    step(R,   1'b1, 2'd0, 0, 0, 0, 1);
    step(RY,  1'b1, 2'd1, 0, 0, 0, 0);
    step(RY,  1'b1, 2'd1, 0, 0, 0, 0);
    step(G,   1'b1, 2'd2, 0, 0, 0, 0);
    step(BAD, 1'b0, 2'd2, 1, 0, 0, 0);
    step(Y,   1'b1, 2'd3, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) step(Y, 1'b1, 2'd3, 0, 0, 0, 0);
    step(R,   1'b1, 2'd0, 0, 0, 0, 1);

    // RED(1) straight to GREEN, then hold GREEN for 5 samples in total.
    step(G, 1'b1, 2'd2, 0, 1, 0, 0);
    for (int j = 0; j < 4; j++) step(G, 1'b1, 2'd2, 0, 0, j == 2, 0);

    // Normal YELLOW, RED, RED_YELLOW, then a GREEN that is one sample short.
    for (int j = 0; j < 4; j++) step(Y, 1'b1, 2'd3, 0, 0, 0, 0);
    step(R,  1'b1, 2'd0, 0, 0, 0, 1);
    step(RY, 1'b1, 2'd1, 0, 0, 0, 0);
    step(RY, 1'b1, 2'd1, 0, 0, 0, 0);
    step(G,  1'b1, 2'd2, 0, 0, 0, 0);
    step(G,  1'b1, 2'd2, 0, 0, 0, 0);
    step(Y,  1'b1, 2'd3, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) step(Y, 1'b1, 2'd3, 0, 0, 0, 0);

    // 260 illegal samples saturate err_count, then relock into YELLOW.
    for (int j = 0; j < 260; j++) step(BAD, 1'b0, 2'd3, 1, 0, 0, 0);
    step(Y, 1'b1, 2'd3, 0, 0, 0, 0);
    step(Y, 1'b1, 2'd3, 0, 0, 0, 0);
    check("err_count_sat", 32'(err_count), 255);

    // Asynchronous reset mid-YELLOW, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset   = 1'b0;
    exp_err = 0;
    exp_cyc = 0;
    step(R,  1'b1, 2'd0, 0, 0, 0, 0);
    step(RY, 1'b1, 2'd1, 0, 0, 0, 0);
    step(RY, 1'b1, 2'd1, 0, 0, 0, 0);
    step(G,  1'b1, 2'd2, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_traffic_lights_monitor

// File: doc/traffic_lights_monitor.md
# traffic_lights_monitor

Passive observer for the red/yellow/green outputs of the traffic-light controller. Samples the three lamp lines every clock, decodes the current phase, and checks pattern legality, phase order (RED → RED_YELLOW → GREEN → YELLOW → RED) and phase durations. It reports per-event error pulses and saturating statistics. It sits beside the controller in the top level and in the bench as the receiving end of the lamp interface.

## Interface
- RED_TIME, 1: required RED phase length, clk cycles (1..254)
- RED_YELLOW_TIME, 2: required RED_YELLOW phase length (1..254)
- GREEN_TIME, 3: required GREEN phase length (1..254)
- YELLOW_TIME, 4: required YELLOW phase length (1..254)
- clk  in  1  clock; lamp lines sampled on posedge
- reset  in  1  reset, asynchronous, active-high
- red, yellow, green  in  1 each  lamp lines from controller
- phase  out  2  tracked phase: 0 RED, 1 RED_YELLOW, 2 GREEN, 3 YELLOW; meaningful only when locked=1
- locked  out  1  monitor is tracking a legal phase
- err_pattern  out  1  one-cycle pulse: illegal lamp combination sampled
- err_sequence  out  1  one-cycle pulse: legal phase change to a non-successor
- err_duration  out  1  one-cycle pulse: phase too long or too short
- err_count  out  8  count of cycles with any err_* high, saturates at 255
- cycle_count  out  16  completed YELLOW→RED transitions, wraps

## Operation
- Decode {red,yellow,green}: 100 RED, 110 RED_YELLOW, 001 GREEN, 010 YELLOW; all other codes, including 000, are illegal.
- Registers: state (HUNT/TRACK), phase, prev_pat[2:0], run_cnt[7:0] (saturating), all outputs.
- Reset values: state=HUNT, prev_pat=000, run_cnt=0, phase=0, locked=0, all err_*=0, err_count=0, cycle_count=0.
- HUNT behaviour:
  - Legal sample that differs from prev_pat → TRACK, phase=decoded, run_cnt=1.
  - No sequence or duration check on this entry.
  - Illegal sample → err_pattern; stay in HUNT.
- TRACK, same pattern as phase:
  - run_cnt+1.
  - When run_cnt becomes expected+1, err_duration pulses (exactly once per phase occurrence).
- TRACK, different legal pattern:
  - err_sequence if the new phase is not the successor of the current phase.
  - err_duration if run_cnt < expected for the ending phase.
  - Then phase=new, run_cnt=1, and stay in TRACK. The monitor resyncs to the observed phase on sequence errors.
  - Legal YELLOW→RED increments cycle_count.
- TRACK, illegal pattern → err_pattern, state=HUNT, locked=0.
- prev_pat is updated with every sample.
- locked=1 exactly while state=TRACK.
- Simultaneous err_sequence and err_duration pulse together; err_count increments by 1 for that cycle.
- Reset is asynchronous and immediate; asserting it mid-phase discards all tracking.

## Timing
- Latency: a sample captured at edge k affects phase, locked, err_* and counters in the cycle after edge k. This is a 1-cycle registered latency.
- All err_* outputs are high for exactly one cycle per event.
- With shared reset against a controller that resets to RED: first post-reset edge samples 100, which differs from prev_pat=000. Result: locked=1 and phase=RED after that edge, and the RED length is measured exactly.
- Total legal period with default parameters is 10 cycles.

## Configuration
- TRAFFIC_LIGHTS_MONITOR_DURATION_CHECK_EN defined:
  - run_cnt and duration checking are present as described.
- Undefined:
  - run_cnt is removed and err_duration is tied 0.
  - Pattern and sequence checks, locked, phase and counters are unchanged.
  - The *_TIME parameters are accepted but unused.

## Test plan
- Shared reset with the controller at default parameters, run 100 cycles:
  - locked=1 from the cycle after the first edge.
  - No err_* pulses.
  - cycle_count=9 or 10 consistent with 10-cycle period.
  - err_count=0.
- Drive legal sequence, then 111 for one cycle mid-GREEN:
  - err_pattern pulse, locked=0, err_count=1.
  - Then 010 gives locked=1, phase=3, and no err_sequence.
- Drive RED(1) → GREEN:
  - err_sequence pulse in the cycle after the GREEN sample.
  - phase=2, err_count+1.
- Hold GREEN 5 cycles:
  - err_duration pulses once, on the cycle after the 4th GREEN sample.
  - No further duration pulse for that phase.
- GREEN for 2 cycles then YELLOW:
  - err_duration pulse on the cycle after the YELLOW sample.
  - No err_sequence.
- Assert reset mid-YELLOW with 260 prior errors:
  - All outputs return to reset values immediately.
  - Before reset, err_count held at 255 (saturated).
